filter_test_sequencer: RTL and testbench

Sequencer for the filter test bench. It drives the exponential signal generator's `test_rate`, `test_overlay` and `test_delay` controls through a programmed sweep of delay values. After each generated pulse it captures the peak of the selected filter output and reports one peak record per pulse. It sits in the filter top level, between the test-control inputs and `exp_sig_gen`, and observes one `vN_filter` output.

---
 rtl/filter_test_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_filter_test_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_test_sequencer.sv
// filter_test_sequencer
//   Steps exp_sig_gen through a programmed sweep of delay values. Every sweep point
//   fires cfg_repeat pulses spaced max(cfg_period,4) cycles apart. After each pulse the
//   signed peak of the observed filter output is captured and reported as one record.
//
// Ports
//   i_clk, i_reset          clock (rising edge) and asynchronous active-low reset
//   i_start, i_abort        sweep request (honoured in idle only) and sweep termination
//   i_cfg_*                 period, delay first/last/step, repeat and overlay; latched at start
//   i_filter_data           observed filter output, two's complement
//   o_test_rate             one-cycle pulse trigger to exp_sig_gen
//   o_test_overlay          overlay control to exp_sig_gen
//   o_test_delay            delay control to exp_sig_gen
//   o_busy                  sweep in progress
//   o_peak_valid            one-cycle strobe qualifying o_peak_value / o_peak_delay
//   o_peak_value            signed maximum of i_filter_data over the last window
//   o_peak_delay            delay value the reported peak belongs to
//   o_done                  one-cycle strobe at normal sweep completion
module filter_test_sequencer #(
    parameter int unsigned SIZE_DELAY       = 8,
    parameter int unsigned SIZE_FILTER_DATA = 16,
    parameter int unsigned SIZE_PERIOD      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [SIZE_PERIOD-1:0]      i_cfg_period,
    input  logic [SIZE_DELAY-1:0]       i_cfg_delay_first,
    input  logic [SIZE_DELAY-1:0]       i_cfg_delay_last,
    input  logic [SIZE_DELAY-1:0]       i_cfg_delay_step,
    input  logic [3:0]                  i_cfg_repeat,
    input  logic                        i_cfg_overlay,
    input  logic [SIZE_FILTER_DATA-1:0] i_filter_data,
    output logic                        o_test_rate,
    output logic                        o_test_overlay,
    output logic [SIZE_DELAY-1:0]       o_test_delay,
    output logic                        o_busy,
    output logic                        o_peak_valid,
    output logic [SIZE_FILTER_DATA-1:0] o_peak_value,
    output logic [SIZE_DELAY-1:0]       o_peak_delay,
    output logic                        o_done
);

    localparam logic [SIZE_FILTER_DATA-1:0] PeakMin   = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};
    localparam logic [SIZE_PERIOD-1:0]      PeriodMin = SIZE_PERIOD'(4);

    typedef enum logic [2:0] {StIdle, StArm, StPulse, StWait, StReport, StDone} state_t;

    state_t                      r_state, w_state;
    logic [SIZE_PERIOD-1:0]      r_period, w_period;
    logic [SIZE_DELAY-1:0]       r_last, w_last;
    logic [SIZE_DELAY-1:0]       r_first, w_first;
    logic [SIZE_DELAY-1:0]       r_step, w_step;
    logic [3:0]                  r_repeat, w_repeat;
    logic                        r_overlay, w_overlay;
    logic [SIZE_DELAY-1:0]       r_delay, w_delay;
    logic [3:0]                  r_rep_cnt, w_rep_cnt;
    logic [SIZE_PERIOD-1:0]      r_cnt, w_cnt;
    logic [SIZE_FILTER_DATA-1:0] r_peak, w_peak;

    // Registered outputs, decoded from the next state so they line up with the state.
    logic                        r_test_rate, r_test_overlay, r_busy, r_peak_valid, r_done;
    logic [SIZE_DELAY-1:0]       r_test_delay, r_peak_delay;
    logic [SIZE_FILTER_DATA-1:0] r_peak_value;
    logic                        w_busy;
    logic [SIZE_FILTER_DATA-1:0] w_peak_value;
    logic [SIZE_DELAY-1:0]       w_peak_delay;

    logic [SIZE_FILTER_DATA-1:0] w_peak_upd;
    logic [SIZE_DELAY:0]         w_next_delay;
    logic                        w_sweep_end;
    logic [3:0]                  w_rep_load;

    assign w_peak_upd   = ($signed(i_filter_data) > $signed(r_peak)) ? i_filter_data : r_peak;
    // One extra bit so that a step past the top of the delay range ends the sweep
    // instead of wrapping back to a small delay.
    assign w_next_delay = {1'b0, r_delay} + {1'b0, r_step};
    assign w_sweep_end  = (r_step == '0) || (w_next_delay > {1'b0, r_last});
    assign w_rep_load   = (r_repeat == 4'd0) ? 4'd0 : r_repeat - 4'd1;

    always_comb begin
        w_state   = r_state;
        w_period  = r_period;
        w_first   = r_first;
        w_last    = r_last;
        w_step    = r_step;
        w_repeat  = r_repeat;
        w_overlay = r_overlay;
        w_delay   = r_delay;
        w_rep_cnt = r_rep_cnt;
        w_cnt     = r_cnt;
        w_peak    = r_peak;

        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_period  = (i_cfg_period < PeriodMin) ? PeriodMin : i_cfg_period;
                    w_first   = i_cfg_delay_first;
                    w_last    = i_cfg_delay_last;
                    w_step    = i_cfg_delay_step;
                    w_repeat  = i_cfg_repeat;
                    w_overlay = i_cfg_overlay;
                    // Early load so o_test_delay is already valid during ARM.
                    w_delay   = i_cfg_delay_first;
                    w_state   = StArm;
                end
            end
            StArm: begin
                w_delay   = r_first;
                w_rep_cnt = w_rep_load;
                w_state   = StPulse;
            end
            StPulse: begin
                w_peak  = PeakMin;
                // PULSE + (period-2) WAIT + REPORT gives exactly one period per pulse.
                w_cnt   = r_period - SIZE_PERIOD'(3);
                w_state = StWait;
            end
            StWait: begin
                w_peak = w_peak_upd;
                if (r_cnt == '0) begin
                    w_state = StReport;
                end else begin
                    w_cnt = r_cnt - SIZE_PERIOD'(1);
                end
            end
            StReport: begin
                if (r_rep_cnt != 4'd0) begin
                    w_rep_cnt = r_rep_cnt - 4'd1;
                    w_state   = StPulse;
                end else if (w_sweep_end) begin
                    w_state = StDone;
                end else begin
                    w_delay   = w_next_delay[SIZE_DELAY-1:0];
                    w_rep_cnt = w_rep_load;
                    w_state   = StPulse;
                end
            end
            StDone: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        if (i_abort && (r_state != StIdle)) begin
            w_state = StIdle;
        end

        w_busy = (w_state != StIdle);
        // The REPORT cycle shows the peak including the last WAIT sample.
        w_peak_value = (w_state == StReport) ? w_peak_upd : r_peak_value;
        w_peak_delay = (w_state == StReport) ? r_delay    : r_peak_delay;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= StIdle;
            r_period       <= '0;
            r_first        <= '0;
            r_last         <= '0;
            r_step         <= '0;
            r_repeat       <= '0;
            r_overlay      <= 1'b0;
            r_delay        <= '0;
            r_rep_cnt      <= '0;
            r_cnt          <= '0;
            r_peak         <= '0;
            r_test_rate    <= 1'b0;
            r_test_overlay <= 1'b0;
            r_test_delay   <= '0;
            r_busy         <= 1'b0;
            r_peak_valid   <= 1'b0;
            r_peak_value   <= '0;
            r_peak_delay   <= '0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_period       <= w_period;
            r_first        <= w_first;
            r_last         <= w_last;
            r_step         <= w_step;
            r_repeat       <= w_repeat;
            r_overlay      <= w_overlay;
            r_delay        <= w_delay;
            r_rep_cnt      <= w_rep_cnt;
            r_cnt          <= w_cnt;
            r_peak         <= w_peak;
            r_test_rate    <= (w_state == StPulse);
            r_test_overlay <= w_busy ? w_overlay : 1'b0;
            r_test_delay   <= w_busy ? w_delay : '0;
            r_busy         <= w_busy;
            r_peak_valid   <= (w_state == StReport);
            r_peak_value   <= w_peak_value;
            r_peak_delay   <= w_peak_delay;
            r_done         <= (w_state == StDone);
        end
    end

    assign o_test_rate    = r_test_rate;
    assign o_test_overlay = r_test_overlay;
    assign o_test_delay   = r_test_delay;
    assign o_busy         = r_busy;
    assign o_peak_valid   = r_peak_valid;
    assign o_peak_value   = r_peak_value;
    assign o_peak_delay   = r_peak_delay;
    assign o_done         = r_done;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// tb_filter_test_sequencer
//   Randomised sweeps against a reference model built from the sweep rules: the list of
//   delay values, the pulse schedule and each window's maximum are computed up front and
//   queued; a negedge monitor pops and compares whenever the DUT reports.
module tb_filter_test_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start, abort;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_first, cfg_last, cfg_step;
    logic [3:0]  cfg_repeat;
    logic        cfg_overlay;
    logic [15:0] filter_data;
    logic        test_rate, test_overlay, busy, peak_valid, done;
    logic [7:0]  test_delay, peak_delay;
    logic [15:0] peak_value;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    int exp_peak_q[$];
    int exp_pd_q[$];
    int exp_rate_q[$];
    int pulse_cyc_q[$];
    int pv_cnt, done_cnt, done_cyc, busy_cnt;
    bit exp_ovl;

    filter_test_sequencer #(
        .SIZE_DELAY       (8),
        .SIZE_FILTER_DATA (16),
        .SIZE_PERIOD      (16)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset_n),
        .i_start           (start),
        .i_abort           (abort),
        .i_cfg_period      (cfg_period),
        .i_cfg_delay_first (cfg_first),
        .i_cfg_delay_last  (cfg_last),
        .i_cfg_delay_step  (cfg_step),
        .i_cfg_repeat      (cfg_repeat),
        .i_cfg_overlay     (cfg_overlay),
        .i_filter_data     (filter_data),
        .o_test_rate       (test_rate),
        .o_test_overlay    (test_overlay),
        .o_test_delay      (test_delay),
        .o_busy            (busy),
        .o_peak_valid      (peak_valid),
        .o_peak_value      (peak_value),
        .o_peak_delay      (peak_delay),
        .o_done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        int d;
        int pk;
        if (busy) begin
            busy_cnt++;
            check("overlay_busy", int'(test_overlay), int'(exp_ovl));
        end
        if (test_rate) begin
            pulse_cyc_q.push_back(cyc);
            if (exp_rate_q.size() == 0) begin
                check("unexpected_rate", 1, 0);
            end else begin
                d = exp_rate_q.pop_front();
                check("rate_delay", int'(test_delay), d);
            end
        end
        if (peak_valid) begin
            pv_cnt++;
            if (exp_peak_q.size() == 0) begin
                check("unexpected_peak", 1, 0);
            end else begin
                pk = exp_peak_q.pop_front();
                d  = exp_pd_q.pop_front();
                check("peak_value", $signed(peak_value), pk);
                check("peak_delay", int'(peak_delay), d);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int gen(input int mode, input int w);
        logic [15:0] t;
        int          neg_tab[6];
        neg_tab = '{-5, -3, -9, -7, -12, -4};
        case (mode)
            0: begin
                t = 16'($urandom);
                return int'($signed(t));
            end
            1: return neg_tab[w % 6];
            2: return w;
            default: return -32768 + w;
        endcase
    endfunction

    task automatic run_sweep(input int period, input int first, input int last, input int step,
                             input int rep, input bit ovl, input int mode, input bit poke);
        int p, r, n, total, s, d, pk, v, last_pk, last_d;
        int dl[$];
        int samp[];
        p = (period < 4) ? 4 : period;
        r = (rep == 0) ? 1 : rep;
        d = first;
        forever begin
            dl.push_back(d);
            if (step == 0 || d + step > last) break;
            d = d + step;
        end
        n       = dl.size();
        total   = 3 + n * r * p;
        samp    = new[total + 4];
        last_pk = 0;
        last_d  = 0;
        foreach (samp[i]) samp[i] = 32767;
        // Pulse k fires in cycle 2+k*p; its window is the p-2 cycles after it.
        for (int k = 0; k < n * r; k++) begin
            pk = -32768;
            for (int w = 0; w < p - 2; w++) begin
                v = gen(mode, w);
                samp[3 + k * p + w] = v;
                if (v > pk) pk = v;
            end
            exp_peak_q.push_back(pk);
            exp_pd_q.push_back(dl[k / r]);
            exp_rate_q.push_back(dl[k / r]);
            last_pk = pk;
            last_d  = dl[k / r];
        end
        exp_ovl  = ovl;
        pulse_cyc_q.delete();
        done_cnt = 0;
        pv_cnt   = 0;
        busy_cnt = 0;

        @(posedge clk); #1;
        s           = cyc;
        cfg_period  = 16'(period);
        cfg_first   = 8'(first);
        cfg_last    = 8'(last);
        cfg_step    = 8'(step);
        cfg_repeat  = 4'(rep);
        cfg_overlay = ovl;
        start       = 1'b1;
        filter_data = 16'(samp[0]);
        for (int j = 1; j < total + 4; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke && j < total - 2) begin
                start       = (j % 5 == 0);
                cfg_period  = 16'($urandom);
                cfg_first   = 8'($urandom);
                cfg_last    = 8'($urandom);
                cfg_step    = 8'($urandom);
                cfg_repeat  = 4'($urandom);
                cfg_overlay = !ovl;
            end
            filter_data = 16'(samp[j]);
        end
        @(negedge clk);
        check("pulse_count", pulse_cyc_q.size(), n * r);
        for (int k = 0; k < pulse_cyc_q.size(); k++) begin
            check("pulse_time", pulse_cyc_q[k] - s, 2 + k * p);
        end
        check("peak_count", pv_cnt, n * r);
        check("done_count", done_cnt, 1);
        check("done_time", done_cyc - s, total - 1);
        // busy covers ARM, all pulse periods and DONE
        check("busy_cycles", busy_cnt, total - 1);
        check("peaks_left", exp_peak_q.size(), 0);
        check("peak_hold", $signed(peak_value), last_pk);
        check("peak_delay_hold", int'(peak_delay), last_d);
        check("idle_busy", int'(busy), 0);
        check("idle_delay", int'(test_delay), 0);
        check("idle_overlay", int'(test_overlay), 0);
    endtask

    task automatic run_abort();
        exp_ovl  = 1'b1;
        pulse_cyc_q.delete();
        done_cnt = 0;
        pv_cnt   = 0;
        exp_rate_q.push_back(5);
        @(posedge clk); #1;
        cfg_period  = 16'd8;
        cfg_first   = 8'd5;
        cfg_last    = 8'd100;
        cfg_step    = 8'd5;
        cfg_repeat  = 4'd1;
        cfg_overlay = 1'b1;
        start       = 1'b1;
        filter_data = 16'd0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            abort       = (j == 5);  // third WAIT cycle of the first pulse
            filter_data = 16'($urandom);
            if (j == 6) begin
                @(negedge clk);
                check("abort_busy", int'(busy), 0);
                check("abort_overlay", int'(test_overlay), 0);
                check("abort_delay", int'(test_delay), 0);
            end
        end
        @(negedge clk);
        check("abort_pulses", pulse_cyc_q.size(), 1);
        check("abort_done", done_cnt, 0);
        check("abort_peaks", pv_cnt, 0);
    endtask

    task automatic run_start_abort();
        pulse_cyc_q.delete();
        busy_cnt = 0;
        @(posedge clk); #1;
        cfg_period = 16'd8;
        cfg_first  = 8'd1;
        cfg_last   = 8'd9;
        cfg_step   = 8'd1;
        start      = 1'b1;
        abort      = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
        @(negedge clk);
        check("start_abort_busy", busy_cnt, 0);
        check("start_abort_pulses", pulse_cyc_q.size(), 0);
    endtask

    task automatic run_reset_mid();
        exp_ovl = 1'b1;
        pulse_cyc_q.delete();
        exp_rate_q.push_back(60);
        @(posedge clk); #1;
        cfg_period  = 16'd8;
        cfg_first   = 8'd60;
        cfg_last    = 8'd200;
        cfg_step    = 8'd20;
        cfg_repeat  = 4'd1;
        cfg_overlay = 1'b1;
        start       = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            filter_data = 16'($urandom);
        end
        check("reset_pre_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_overlay", int'(test_overlay), 0);
        check("reset_delay", int'(test_delay), 0);
        check("reset_peak_value", int'(peak_value), 0);
        check("reset_peak_delay", int'(peak_delay), 0);
        @(posedge clk);
        @(posedge clk); #3;
        reset_n = 1'b1;
        exp_rate_q.delete();
        exp_peak_q.delete();
        exp_pd_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_after_busy", int'(busy), 0);
        check("reset_pulses", pulse_cyc_q.size(), 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_period  = '0;
        cfg_first   = '0;
        cfg_last    = '0;
        cfg_step    = '0;
        cfg_repeat  = '0;
        cfg_overlay = 1'b0;
        filter_data = '0;
        exp_ovl     = 1'b0;
        pv_cnt      = 0;
        done_cnt    = 0;
        done_cyc    = 0;
        busy_cnt    = 0;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_rate", int'(test_rate), 0);
        check("rst_delay", int'(test_delay), 0);
        check("rst_peak_valid", int'(peak_valid), 0);
        check("rst_peak_value", int'(peak_value), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_sweep(8, 10, 30, 10, 2, 1'b1, 1, 1'b0);   // all-negative windows
        run_sweep(8, 10, 30, 10, 2, 1'b0, 2, 1'b0);   // ramp windows
        run_reset_mid();
        run_sweep(8, 250, 255, 10, 1, 1'b0, 0, 1'b0); // no wrap past 255
        run_sweep(6, 7, 100, 0, 1, 1'b1, 0, 1'b0);    // step 0
        run_sweep(5, 40, 20, 3, 2, 1'b0, 3, 1'b0);    // first > last
        run_sweep(2, 0, 20, 10, 0, 1'b1, 2, 1'b0);    // period and repeat clamps
        run_abort();
        run_sweep(7, 3, 60, 19, 2, 1'b1, 0, 1'b1);    // start/cfg pokes while busy
        run_start_abort();
        for (int i = 0; i < 6; i++) begin
            run_sweep($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 255),
                      ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(15, 90),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
